// File: rtl/alu_sequencer.sv
// alu_sequencer
//   Command-driven controller wrapped around an external 4-bit Alu.
//   Holds a small register file, accepts one command at a time over a
//   valid/ready handshake, drives the Alu from registers, waits a fixed
//   settle time, writes the Alu result back and returns it on a
//   valid/ready response channel.
//
// Ports
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   cmd_valid / cmd_ready    command handshake (ready only while IDLE)
//   cmd_kind                 00 ALU, 01 LDI, 10 RD, 11 reserved
//   cmd_op/rd/ra/rb/imm      command fields, sampled on the accept edge
//   alu_a/alu_b/alu_op       registered Alu operands
//   alu_c/alu_v/alu_carry    Alu results
//   rsp_valid / rsp_ready    response handshake
//   rsp_data/v/carry/err     response payload, stable while rsp_valid
module alu_sequencer #(
  parameter int NREGS       = 4,
  parameter int EXEC_CYCLES = 1,
  localparam int RW         = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_kind,
  input  logic [3:0]    cmd_op,
  input  logic [RW-1:0] cmd_rd,
  input  logic [RW-1:0] cmd_ra,
  input  logic [RW-1:0] cmd_rb,
  input  logic [3:0]    cmd_imm,
  output logic [3:0]    alu_a,
  output logic [3:0]    alu_b,
  output logic [3:0]    alu_op,
  input  logic [3:0]    alu_c,
  input  logic          alu_v,
  input  logic          alu_carry,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [3:0]    rsp_data,
  output logic          rsp_v,
  output logic          rsp_carry,
  output logic          rsp_err
);

  localparam logic [1:0] K_ALU = 2'b00;
  localparam logic [1:0] K_LDI = 2'b01;
  localparam logic [1:0] K_RD  = 2'b10;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  typedef struct packed {
    logic [3:0] data;
    logic       v;
    logic       carry;
    logic       err;
  } rsp_t;

  state_t                 state, nxt;
  logic [NREGS-1:0][3:0]  rf;
  logic [RW-1:0]          rd_q;
  logic [3:0]             cnt;
  rsp_t                   rsp_q;

  wire accept = cmd_valid & cmd_ready;

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // next state and handshake outputs
  always_comb begin
    nxt       = state;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) nxt = (cmd_kind == K_ALU) ? EXEC : RESP;
      end
      EXEC: if (cnt == 4'd0) nxt = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // datapath: register file, Alu operand registers, response payload.
  // Operand reads happen on the accept edge, so rd==ra/rb sees the old value
  // and every command sees the previous command's completed writeback.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf     <= '0;
      alu_a  <= '0;
      alu_b  <= '0;
      alu_op <= '0;
      rd_q   <= '0;
      cnt    <= '0;
      rsp_q  <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          case (cmd_kind)
            K_ALU: begin
              alu_a  <= rf[cmd_ra];
              alu_b  <= rf[cmd_rb];
              alu_op <= cmd_op;
              rd_q   <= cmd_rd;
              cnt    <= 4'(EXEC_CYCLES - 1);
            end
            K_LDI: begin
              rf[cmd_rd] <= cmd_imm;
              rsp_q      <= '{data: cmd_imm, v: 1'b0, carry: 1'b0, err: 1'b0};
            end
            K_RD:  rsp_q <= '{data: rf[cmd_ra], v: 1'b0, carry: 1'b0, err: 1'b0};
            default: rsp_q <= '{data: 4'h0, v: 1'b0, carry: 1'b0, err: 1'b1};
          endcase
        end
        EXEC: begin
          // Alu inputs have been stable EXEC_CYCLES cycles when cnt hits 0
          if (cnt == 4'd0) begin
            rf[rd_q] <= alu_c;
            rsp_q    <= '{data: alu_c, v: alu_v, carry: alu_carry, err: 1'b0};
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp_data  = rsp_q.data;
  assign rsp_v     = rsp_q.v;
  assign rsp_carry = rsp_q.carry;
  assign rsp_err   = rsp_q.err;

endmodule
